// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word at PC, holds it for the core until
// exec_done, then advances PC by sequential, branch or jump rules.
module inst_fetch (
  input  logic        inclk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] PC,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic        armed;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  // Jump wins over branch; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc4    = PC + 32'd4;
    br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
    if (jump)
      next_pc = {pc4[31:28], inst[25:0], 2'b00};
    else if (branch_taken)
      next_pc = pc4 + br_off;
    else
      next_pc = pc4;
  end

  assign im_addr = PC;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET;
      armed      <= 1'b0;
      PC         <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      im_req     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      case (state)
        // RESET spends one full clock after release so the first request
        // appears on the second rising edge.
        RESET: begin
          if (armed) begin
            state  <= FETCH;
            im_req <= 1'b1;
          end else begin
            armed <= 1'b1;
          end
        end
        FETCH: begin
          if (im_ack) begin
            inst       <= im_rdata;
            im_req     <= 1'b0;
            inst_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            PC         <= next_pc;
            retire_cnt <= retire_cnt + 32'd1;
            inst_valid <= 1'b0;
            im_req     <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state      <= RESET;
          armed      <= 1'b0;
          inst_valid <= 1'b0;
          im_req     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized transactions checked
// against a transaction-level model of PC, instruction and retire count.
module tb_inst_fetch;

  logic        inclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] PC;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] retire_cnt;

  inst_fetch dut (
    .inclk       (inclk),
    .rst_n       (rst_n),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .PC          (PC),
    .exec_done   (exec_done),
    .jump        (jump),
    .branch_taken(branch_taken),
    .retire_cnt  (retire_cnt)
  );

  always #5 inclk = ~inclk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input bit j, input bit b);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b) begin
      off = $signed(ins[15:0]);
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    PC,                 32'h0);
    check({tag, "_inst"},  inst,               32'h0);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
    check({tag, "_req"},   {31'b0, im_req},    32'h0);
    check({tag, "_cnt"},   retire_cnt,         32'h0);
  endtask

  // Release reset just after an edge; request must show after the second edge.
  task automatic release_reset();
    rst_n = 1'b1;
    tick();
    check("rel_edge1_req", {31'b0, im_req}, 32'h0);
    tick();
    check("rel_edge2_req", {31'b0, im_req}, 32'h1);
    check("rel_edge2_addr", im_addr, 32'h0);
    m_pc = '0; m_inst = '0; m_cnt = '0;
  endtask

  // One whole instruction: memory waits, issue stall, then retire.
  // Called #1 after an edge with the DUT expected to be fetching.
  task automatic run_insn(input int waits, input logic [31:0] word, input int stall,
                          input bit j, input bit b, input bit spur, input bit force_cnt);
    for (int i = 0; i <= waits; i++) begin
      check("fetch_req",   {31'b0, im_req},     32'h1);
      check("fetch_addr",  im_addr,             m_pc);
      check("fetch_valid", {31'b0, inst_valid}, 32'h0);
      check("fetch_inst",  inst,                m_inst);
      if (i == waits) begin
        im_ack = 1'b1; im_rdata = word;
      end else begin
        im_ack = 1'b0; im_rdata = $urandom;
      end
      exec_done = $urandom; jump = $urandom; branch_taken = $urandom;
      tick();
    end
    im_ack = 1'b0;
    m_inst = word;
    for (int i = 0; i <= stall; i++) begin
      check("issue_valid", {31'b0, inst_valid}, 32'h1);
      check("issue_req",   {31'b0, im_req},     32'h0);
      check("issue_inst",  inst,                m_inst);
      check("issue_pc",    PC,                  m_pc);
      check("issue_cnt",   retire_cnt,          m_cnt);
      if (force_cnt && i == 0) begin
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        check("forced_cnt", retire_cnt, m_cnt);
      end
      if (i == stall) begin
        exec_done = 1'b1; jump = j; branch_taken = b;
        im_ack = 1'b0;
      end else begin
        exec_done = 1'b0; jump = i[0]; branch_taken = $urandom;
        im_ack = spur; im_rdata = ~m_inst;
      end
      tick();
    end
    exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0; im_ack = 1'b0;
    m_pc  = ref_next(m_pc, m_inst, j, b);
    m_cnt = m_cnt + 32'd1;
  endtask

  initial begin
    m_pc = '0; m_inst = '0; m_cnt = '0;

    // Reset held across several edges with noisy inputs.
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF; exec_done = 1'b1;
    repeat (3) tick();
    check_reset_values("in_reset");
    im_ack = 1'b0; exec_done = 1'b0;
    release_reset();

    // Sequential addi run, zero wait, immediate retire: PC 0,4,8,C.
    for (int n = 0; n < 4; n++)
      run_insn(0, 32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_cnt", retire_cnt, 32'd4);
    check("seq_pc",  PC,         32'h10);

    // Branch -4 words at PC 0x10 lands on 0x4.
    run_insn(0, 32'h1000_FFFC, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("branch_pc", PC, 32'h4);

    // Three wait states, spurious acks during issue; branch back wraps below 0.
    run_insn(3, 32'h1000_FFFC, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    check("branch_wrap_pc", PC, 32'hFFFF_FFF8);

    // Jump keeps pc4's top nibble.
    run_insn(1, 32'h0800_0000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jump_hi_pc", PC, 32'hF000_0000);
    run_insn(0, 32'h0800_0040, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jump_pc", PC, 32'hF000_0100);

    // Jump and branch together: jump target wins.
    run_insn(0, 32'h0BFF_FFFF, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_pc", PC, 32'hFFFF_FFFC);

    // Sequential wrap with a 10-cycle stall while jump toggles.
    run_insn(2, 32'h2008_0005, 10, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pc_wrap", PC, 32'h0);

    // Retire counter wrap.
    run_insn(0, 32'h2008_0005, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("cnt_wrap", retire_cnt, 32'h0);

    // Reach FETCH at 0x40, then reset asynchronously mid-fetch.
    run_insn(0, 32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_addr", im_addr, 32'h40);
    check("pre_rst_req",  {31'b0, im_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (2) tick();
    check_reset_values("async_rst_hold");
    release_reset();

    // Randomized transactions.
    for (int n = 0; n < 40; n++)
      run_insn($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("rand_cnt", retire_cnt, 32'd40);
    check("rand_pc",  PC,         m_pc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset: inclk is the sole clock, and rst_n is the asynchronous reset, active low.
REQ-002 inclk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 im_req  out  1  instruction-memory read request.
REQ-005 im_addr  out  32  byte address of the requested word; always equals PC.
REQ-006 im_ack  in  1  memory response valid; im_rdata is valid in the same cycle.
REQ-007 im_rdata  in  32  instruction word from memory.
REQ-008 inst  out  32  registered instruction presented to the decoder.
REQ-009 inst_valid  out  1  inst is stable and executable.
REQ-010 PC  out  32  address of the current instruction.
REQ-011 exec_done  in  1  the core has finished executing inst and accepts the next PC.
REQ-012 jump  in  1  decoder jump select, meaning a j instruction.
REQ-013 branch_taken  in  1  decoder branch-taken select (beq&zero | bne&~zero).
REQ-014 retire_cnt  out  32  count of retired instructions.

Function
REQ-015 The FSM SHALL have three states: RESET, FETCH and ISSUE.
REQ-016 RESET SHALL last one cycle after rst_n deasserts, then go to FETCH.
REQ-017 FETCH:
- im_req=1 and im_addr=PC, held stable until im_ack.
- On a rising edge with im_ack=1: inst<=im_rdata, go to ISSUE.
REQ-018 A zero-wait ack is legal: im_ack in the first FETCH cycle SHALL give inst_valid=1 on the next cycle.
REQ-019 ISSUE:
- inst_valid=1, im_req=0.
- inst and PC are held constant until exec_done=1.
REQ-020 On a rising edge in ISSUE with exec_done=1:
- PC<=next_pc.
- retire_cnt<=retire_cnt+1.
- Go to FETCH.
- inst_valid deasserts the following cycle.
REQ-021 next_pc SHALL be evaluated from inst, jump and branch_taken in the same cycle as exec_done:
- pc4 = PC+4, modulo 2^32.
- If jump: {pc4[31:28], inst[25:0], 2'b00}.
- Else if branch_taken: pc4 + (sign-extended inst[15:0] << 2), modulo 2^32.
- Else: pc4.
REQ-022 If jump and branch_taken are both 1, jump SHALL take priority.
REQ-023 PC[1:0] SHALL always be 2'b00.
REQ-024 PC arithmetic SHALL wrap: PC=32'hFFFF_FFFC with no branch or jump gives next_pc=32'h0000_0000.
REQ-025 Branches SHALL wrap in both directions, so a negative offset from a low address wraps to a high address.
REQ-026 retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 im_ack SHALL be ignored outside FETCH and SHALL NOT change inst.
REQ-028 exec_done, jump and branch_taken SHALL be ignored outside ISSUE.
REQ-029 At most one instruction SHALL be outstanding; im_req SHALL never assert in ISSUE or RESET.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles, given a zero-wait ack and exec_done asserted in the first ISSUE cycle.

Reset
REQ-031 While rst_n=0, regardless of clock:
- PC=32'h0000_0000, inst=32'h0000_0000.
- inst_valid=0, im_req=0, retire_cnt=0.
- State=RESET.
REQ-032 A reset asserted mid-FETCH or mid-ISSUE SHALL abort the operation and discard any outstanding request.
REQ-033 The instruction memory SHALL share rst_n, so no stale im_ack can arrive after reset.
REQ-034 After rst_n rises, the first im_req SHALL assert on the second rising edge, with im_addr=0.

Verification
REQ-035 Sequential run:
- Stimulus: zero-wait memory returning 32'h2008_0005 (addi), exec_done held at 1, 4 instructions.
- Required response: PC=0,4,8,C; inst_valid toggles every cycle; retire_cnt=4.
REQ-036 Wait states:
- Stimulus: im_ack delayed 3 cycles.
- Required response: im_req and im_addr stable for 4 cycles; inst updates only on the ack edge; a spurious im_ack injected in ISSUE leaves inst unchanged.
REQ-037 Branch and jump:
- Branch stimulus: PC=32'h0000_0010, inst=32'h1000_FFFC, branch_taken=1. Required response: next PC=32'h0000_0004.
- Jump stimulus: PC=32'hF000_0000, inst=32'h0800_0040. Required response: next PC=32'hF000_0100.
- Priority stimulus: jump and branch_taken both 1. Required response: the jump target is taken.
REQ-038 Wrap:
- PC stimulus: PC=32'hFFFF_FFFC, sequential. Required response: next PC=0.
- Counter stimulus: retire_cnt preloaded via 2^32-1 retirements, or forced. Required response: retire_cnt wraps to 0.
REQ-039 Stall and ignore:
- Stimulus: exec_done=0 for 10 ISSUE cycles while jump toggles.
- Required response: PC and inst unchanged.
REQ-040 Mid-operation reset:
- Stimulus: rst_n pulsed low asynchronously during FETCH with PC=32'h40.
- Required response: outputs go to reset values immediately; fetch restarts at address 0.
